uart_deserializer: RTL
======================

Name: uart_deserializer

Overview:
UART receive stage; the line-side counterpart of the UART serializer. It oversamples the asynchronous rx line, recovers 8N1 frames (LSB first), and pushes each good byte into the downstream RX FIFO through a single-cycle write strobe. It flags framing errors and overruns as one-cycle pulses for the status/CSR block. It sits between the pad-side rx input and the RX FIFO write port.

Parameters:
OVERSAMPLE, 16, sample_en_i ticks per bit period; even, >= 4
SYNC_STAGES, 2, flops in the rx input synchronizer; >= 2

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
sample_en_i  input  1  oversample tick at OVERSAMPLE x baud, one clk wide
rx_i  input  1  asynchronous serial line, idle high
fifo_full_i  input  1  RX FIFO full
fifo_wr_en_o  output  1  one-cycle write strobe to RX FIFO
fifo_wr_data_o  output  8  received byte, valid when fifo_wr_en_o=1
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_err_o  output  1  one-cycle pulse: good byte dropped, FIFO full
parity_err_o  output  1  one-cycle pulse: parity mismatch (tied 0 without macro)
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0. Synchronizer flops reset to 1. State returns to IDLE. Counters and shift register reset to 0.
- rx_s is rx_i after SYNC_STAGES flops. All decisions use rx_s.
- Counters: sample_cnt is $clog2(OVERSAMPLE) bits. bit_cnt is 3 bits.
- All counting and sampling happen only on cycles with sample_en_i=1. State is held otherwise.
- IDLE: on a tick with rx_s=0, go to START with sample_cnt=0.
- START: increment sample_cnt each tick. At sample_cnt==OVERSAMPLE/2-1 (mid-start):
  - rx_s=0: go to DATA with sample_cnt=0, bit_cnt=0.
  - rx_s=1: glitch; go to IDLE with no outputs.
- DATA: sample at sample_cnt==OVERSAMPLE-1 (the centre of each bit); sample_cnt wraps to 0 there.
  - Shift rx_s into shift_reg[7], shifting right, so the first bit ends in bit 0.
  - bit_cnt increments. After the sample with bit_cnt==7, go to STOP (or PARITY with the macro).
- STOP: sample at sample_cnt==OVERSAMPLE-1.
  - rx_s=1 and fifo_full_i=0: fifo_wr_en_o=1 for one clk, fifo_wr_data_o=shift_reg; go to IDLE.
  - rx_s=1 and fifo_full_i=1: overrun_err_o=1 for one clk, no write; go to IDLE.
  - rx_s=0: frame_err_o=1 for one clk, no write; go to WAIT_HIGH.
- WAIT_HIGH: on a tick with rx_s=1, go to IDLE. Break/low line never re-triggers a start.
- Latency: strobes/pulses are registered and assert on the clk after the sampling tick. fifo_wr_data_o holds until the next write.
- fifo_full_i is evaluated on the stop-sample tick only.
- Back-to-back frames: a start edge on the first tick after returning to IDLE is accepted. No dead time beyond the stop-centre to stop-end half bit.
- Reset mid-frame: immediate return to IDLE. No write and no error pulse on or after reset.
- Never more than one of fifo_wr_en_o / frame_err_o / overrun_err_o / parity_err_o high in a cycle.

Optional Feature:
UART_RX_PARITY_EN
- Defined: a PARITY state sits between DATA and STOP. One even-parity bit is sampled at bit centre.
- Mismatch: parity_err_o pulses 1 clk on the stop-sample result cycle, and the byte is not written. Framing error takes priority over parity error, and parity error takes priority over overrun.
- Undefined: no PARITY state, 8N1 only, parity_err_o tied 0.

Test Plan:
1. OVERSAMPLE=16, sample_en_i every 4 clk; send 8N1 byte 0xA5 with fifo_full_i=0 -> exactly one fifo_wr_en_o pulse with fifo_wr_data_o=0xA5; busy_o low afterwards; no error pulses.
2. Drive rx_i low for 4 ticks then high (glitch) -> no write and no errors; busy_o high then low; next frame 0x3C received as 0x3C.
3. Send 0x3C with stop bit 0, hold rx low for 40 ticks, then high -> one frame_err_o pulse, no write; no new frame decoded while low; a following 0x55 is received correctly.
4. fifo_full_i=1, send 0x81 -> one overrun_err_o pulse, no fifo_wr_en_o; drop fifo_full_i, send 0x7E -> write of 0x7E.
5. Back-to-back 0x00 then 0xFF with no idle gap -> two writes, 0x00 then 0xFF. Then assert rst during data bit 3 of 0x5A -> all outputs 0 and no write; the resent 0x5A is received correctly.
6. With UART_RX_PARITY_EN defined: send 0x07 with parity bit 0 (even parity requires 1) -> parity_err_o pulse, no write. Send 0x07 with parity bit 1 -> write of 0x07.

Source files
------------

// File: rtl/uart_deserializer.sv
// uart_deserializer: oversampled 8N1 UART receiver pushing good bytes into the RX FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_deserializer #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en_i,
    input  logic       rx_i,
    input  logic       fifo_full_i,
    output logic       fifo_wr_en_o,
    output logic [7:0] fifo_wr_data_o,
    output logic       frame_err_o,
    output logic       overrun_err_o,
    output logic       parity_err_o,
    output logic       busy_o
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd5;
    logic par_bit;
`endif
    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             state;
    logic [CW-1:0]          sample_cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg;
    logic                   rx_s;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign busy_o = state != IDLE;
`ifndef UART_RX_PARITY_EN
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q         <= '1;
            state          <= IDLE;
            sample_cnt     <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            fifo_wr_en_o   <= 1'b0;
            fifo_wr_data_o <= '0;
            frame_err_o    <= 1'b0;
            overrun_err_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o   <= 1'b0;
            par_bit        <= 1'b0;
`endif
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], rx_i};
            fifo_wr_en_o  <= 1'b0;
            frame_err_o   <= 1'b0;
            overrun_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o  <= 1'b0;
`endif
            if (sample_en_i) begin
                case (state)
                    IDLE: if (!rx_s) begin
                        state      <= START;
                        sample_cnt <= '0;
                    end
                    START: if (sample_cnt == MID) begin
                        // A start bit that is high again at its centre was line noise
                        state      <= rx_s ? IDLE : DATA;
                        sample_cnt <= '0;
                        bit_cnt    <= '0;
                    end else sample_cnt <= sample_cnt + CW'(1);
                    DATA: if (sample_cnt == LAST) begin
                        sample_cnt <= '0;
                        shift_reg  <= {rx_s, shift_reg[7:1]};
                        bit_cnt    <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bit_cnt == 3'd7) state <= PARITY;
`else
                        if (bit_cnt == 3'd7) state <= STOP;
`endif
                    end else sample_cnt <= sample_cnt + CW'(1);
`ifdef UART_RX_PARITY_EN
                    PARITY: if (sample_cnt == LAST) begin
                        sample_cnt <= '0;
                        par_bit    <= rx_s;
                        state      <= STOP;
                    end else sample_cnt <= sample_cnt + CW'(1);
`endif
                    STOP: if (sample_cnt == LAST) begin
                        sample_cnt <= '0;
                        if (!rx_s) begin
                            frame_err_o <= 1'b1;
                            state       <= WAIT_HIGH;
                        end else begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bit != ^shift_reg) parity_err_o <= 1'b1;
                            else if (fifo_full_i) overrun_err_o <= 1'b1;
`else
                            if (fifo_full_i) overrun_err_o <= 1'b1;
`endif
                            else begin
                                fifo_wr_en_o   <= 1'b1;
                                fifo_wr_data_o <= shift_reg;
                            end
                        end
                    end else sample_cnt <= sample_cnt + CW'(1);
                    // A held-low break must release before another start is looked for
                    WAIT_HIGH: if (rx_s) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
